display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the board's four-digit common-anode 7-segment display. It takes four hex digits from the arithmetic datapath (adder result and operands) and shares the single segment bus among the four anodes. Each digit is driven for a fixed slot, with an anti-ghosting guard at the start of every slot. New display values are loaded through a request/acknowledge handshake and applied only at frame boundaries, so the display never tears.

---
 rtl/display_scan_ctrl.sv | 119 +++++++++++
 tb/tb_display_scan_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with a dark guard at the start of every slot
// and frame-aligned display updates loaded through a request/acknowledge handshake.
module display_scan_ctrl #(
    parameter int DIV   = 100000,
    parameter int GUARD = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blank_in,
    input  logic [3:0]  dp_in,
    input  logic        upd_req,
    output logic        upd_busy,
    output logic        upd_ack,
    output logic        frame_tick,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int CW = $clog2(DIV);

    // pos_cnt/pos_idx give the slot position of the cycle that starts at the next clock edge,
    // so each registered output shows that position in the very cycle it belongs to.
    logic [CW-1:0] pos_cnt;
    logic [1:0]    pos_idx;
    logic [15:0]   sh_digits, act_digits, nxt_digits;
    logic [3:0]    sh_blank, act_blank, nxt_blank;
    logic [3:0]    sh_dp, act_dp, nxt_dp;
    logic          pending;
    logic          frame_start, do_xfer, in_guard, lit, slot_end;
    logic [3:0]    cur_hex;

    // Handshake: upd_req is accepted on any edge where upd_busy is low; upd_busy then stays high
    // until the frame boundary that applies the update, marked by a one-cycle upd_ack.
    assign upd_busy = pending;

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (pos_cnt < CW'(GUARD));
        end
    endgenerate

    function automatic logic [6:0] decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end    = (pos_cnt == CW'(DIV - 1));
        frame_start = (pos_cnt == '0) && (pos_idx == 2'd0);
        do_xfer     = frame_start && pending;
        nxt_digits  = do_xfer ? sh_digits : act_digits;
        nxt_blank   = do_xfer ? sh_blank  : act_blank;
        nxt_dp      = do_xfer ? sh_dp     : act_dp;
        cur_hex     = nxt_digits[{pos_idx, 2'b00} +: 4];
        lit         = !in_guard && !nxt_blank[pos_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_cnt    <= '0;
            pos_idx    <= 2'd0;
            sh_digits  <= 16'h0000;
            sh_blank   <= 4'h0;
            sh_dp      <= 4'h0;
            act_digits <= 16'h0000;
            act_blank  <= 4'h0;
            act_dp     <= 4'h0;
            pending    <= 1'b0;
            upd_ack    <= 1'b0;
            frame_tick <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
        end else begin
            pos_cnt <= slot_end ? '0 : pos_cnt + 1'b1;
            if (slot_end) begin
                pos_idx <= pos_idx + 1'b1;
            end
            // Transfer uses the old pending flag, so a capture on a boundary edge waits a frame.
            if (do_xfer) begin
                act_digits <= sh_digits;
                act_blank  <= sh_blank;
                act_dp     <= sh_dp;
                pending    <= 1'b0;
            end else if (upd_req && !pending) begin
                sh_digits <= digits_in;
                sh_blank  <= blank_in;
                sh_dp     <= dp_in;
                pending   <= 1'b1;
            end
            upd_ack    <= do_xfer;
            frame_tick <= frame_start;
            an         <= lit ? ~(4'b0001 << pos_idx) : 4'b1111;
            seg        <= lit ? decode(cur_hex) : 7'b1111111;
            dp         <= lit ? ~nxt_dp[pos_idx] : 1'b1;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with DIV=4, GUARD=1: directed scenarios push the
// expected per-cycle outputs into a queue and a negedge monitor pops and compares them.
module tb_display_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  blank_in = 4'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        upd_req = 1'b0;
    logic        upd_busy, upd_ack, frame_tick, dp;
    logic [3:0]  an;
    logic [6:0]  seg;

    logic [14:0] exp_q[$];
    int          tag_q[$];
    int          checks = 0;
    int          failures = 0;
    int          t = 0;
    logic [15:0] disp_d = 16'h0000;
    logic [3:0]  disp_b = 4'h0;
    logic [3:0]  disp_p = 4'h0;

    display_scan_ctrl #(.DIV(4), .GUARD(1)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .blank_in(blank_in), .dp_in(dp_in),
        .upd_req(upd_req), .upd_busy(upd_busy), .upd_ack(upd_ack), .frame_tick(frame_tick),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Packed as {an, seg, dp, upd_busy, upd_ack, frame_tick}.
    function automatic logic [14:0] expv(input int tt, input logic eb, input logic ea);
        int         s, c;
        logic       lit;
        logic [3:0] a;
        logic [6:0] sg;
        logic       d;
        s   = (tt / 4) % 4;
        c   = tt % 4;
        lit = (c >= 1) && !disp_b[s];
        a   = 4'b1111;
        sg  = 7'b1111111;
        d   = 1'b1;
        if (lit) begin
            a     = 4'b1111;
            a[s]  = 1'b0;
            sg    = seg_of(disp_d[4*s +: 4]);
            d     = ~disp_p[s];
        end
        return {a, sg, d, eb, ea, ((tt % 16) == 0)};
    endfunction

    task automatic push_reset();
        exp_q.push_back({4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0, 1'b0});
        tag_q.push_back(-1);
    endtask

    task automatic run(input int n, input logic req, input logic eb, input logic ea);
        for (int i = 0; i < n; i++) begin
            upd_req = req;
            exp_q.push_back(expv(t, eb, ea));
            tag_q.push_back(t);
            @(posedge clk); #1;
            t++;
        end
    endtask

    task automatic do_reset(input logic live, input logic eb);
        upd_req = 1'b0;
        rst = 1'b1;
        if (live) begin
            exp_q.push_back(expv(t, eb, 1'b0));
            tag_q.push_back(t);
        end
        @(posedge clk); #1;
        repeat (2) begin
            push_reset();
            @(posedge clk); #1;
        end
        rst = 1'b0;
        push_reset();
        @(posedge clk); #1;
        t = 0;
        disp_d = 16'h0000;
        disp_b = 4'h0;
        disp_p = 4'h0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [14:0] e, a;
            int          tg;
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            a  = {an, seg, dp, upd_busy, upd_ack, frame_tick};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs cycle %0d: got an=%b seg=%b dp=%b busy=%b ack=%b tick=%b, want an=%b seg=%b dp=%b busy=%b ack=%b tick=%b",
                         tg, a[14:11], a[10:4], a[3], a[2], a[1], a[0],
                         e[14:11], e[10:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        do_reset(1'b0, 1'b0);
        // Reset release: idle scan of "0000" for three frames.
        run(48, 1'b0, 1'b0, 1'b0);
        // Mid-frame update at cycle 5 of the frame.
        run(5, 1'b0, 1'b0, 1'b0);
        digits_in = 16'h12C8;
        run(1, 1'b1, 1'b0, 1'b0);
        digits_in = 16'h0000;
        run(10, 1'b0, 1'b1, 1'b0);
        disp_d = 16'h12C8;
        run(1, 1'b0, 1'b0, 1'b1);
        run(15, 1'b0, 1'b0, 1'b0);
        // Request while busy: 1111 captured, 2222 held and recaptured after the ack.
        run(2, 1'b0, 1'b0, 1'b0);
        digits_in = 16'h1111;
        run(1, 1'b1, 1'b0, 1'b0);
        digits_in = 16'h2222;
        run(13, 1'b1, 1'b1, 1'b0);
        disp_d = 16'h1111;
        run(1, 1'b1, 1'b0, 1'b1);
        digits_in = 16'h0000;
        run(15, 1'b0, 1'b1, 1'b0);
        disp_d = 16'h2222;
        run(1, 1'b0, 1'b0, 1'b1);
        run(15, 1'b0, 1'b0, 1'b0);
        // Blank digits 0 and 2, decimal point on digit 1.
        digits_in = 16'h9467;
        blank_in  = 4'b0101;
        dp_in     = 4'b0010;
        run(1, 1'b1, 1'b0, 1'b0);
        digits_in = 16'h0000;
        blank_in  = 4'h0;
        dp_in     = 4'h0;
        run(15, 1'b0, 1'b1, 1'b0);
        disp_d = 16'h9467;
        disp_b = 4'b0101;
        disp_p = 4'b0010;
        run(1, 1'b0, 1'b0, 1'b1);
        run(31, 1'b0, 1'b0, 1'b0);
        // Reset during slot 2 with an update pending: it must be discarded.
        digits_in = 16'h9999;
        run(1, 1'b1, 1'b0, 1'b0);
        digits_in = 16'h0000;
        run(8, 1'b0, 1'b1, 1'b0);
        do_reset(1'b1, 1'b1);
        run(48, 1'b0, 1'b0, 1'b0);
        // Boundary collision: request on the last cycle of a frame.
        run(15, 1'b0, 1'b0, 1'b0);
        digits_in = 16'h3DB7;
        run(1, 1'b1, 1'b0, 1'b0);
        digits_in = 16'h0000;
        run(16, 1'b0, 1'b1, 1'b0);
        disp_d = 16'h3DB7;
        run(1, 1'b0, 1'b0, 1'b1);
        run(15, 1'b0, 1'b0, 1'b0);
        // Remaining hex glyphs.
        digits_in = 16'h5AEF;
        run(1, 1'b1, 1'b0, 1'b0);
        digits_in = 16'h0000;
        run(15, 1'b0, 1'b1, 1'b0);
        disp_d = 16'h5AEF;
        run(1, 1'b0, 1'b0, 1'b1);
        run(15, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
